// File: rtl/psum_buffer.sv
// rtl/psum_buffer.sv - partial-sum buffer: accumulates tile_count tiles via an external accumulator, then holds the result
module psum_buffer #(
    parameter int acc_width       = 18,
    parameter int actual_width    = 21,
    parameter int systolic_column = 16,
    parameter int pe_blk_count    = 16,
    parameter int tile_count      = 16
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              in_valid,
    output logic                                              in_ready,
    input  logic [pe_blk_count*acc_width*systolic_column-1:0]    psum_in,
    output logic [pe_blk_count*actual_width*systolic_column-1:0] acc_b,
    input  logic [pe_blk_count*actual_width*systolic_column-1:0] acc_sum,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic [pe_blk_count*actual_width*systolic_column-1:0] out_data,
    output logic [$clog2(tile_count+1)-1:0]                   tile_idx
);

    localparam int idx_width = $clog2(tile_count + 1);
    localparam int sum_width = pe_blk_count * actual_width * systolic_column;
    localparam logic [idx_width-1:0] last_idx = idx_width'(tile_count - 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t               state;
    state_t               state_next;
    logic                 in_fire;
    logic                 last_tile;
    logic [sum_width-1:0] acc_reg;

    // psum_in feeds Accumulator A outside this block; it is only observed here.
    logic unused_psum;
    assign unused_psum = ^psum_in;

    assign in_fire   = in_valid && in_ready;
    assign last_tile = (tile_idx == last_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL: begin
                if (in_fire && last_tile) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                // Consuming the result while a new tile arrives keeps the pipe full.
                if (out_ready) begin
                    state_next = (in_fire && last_tile) ? HOLD : FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_comb begin
        out_valid = (state == HOLD);
        in_ready  = (state == FILL) || out_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile_idx <= '0;
            acc_reg  <= '0;
        end else if (in_fire) begin
            acc_reg  <= acc_sum;
            tile_idx <= last_tile ? '0 : tile_idx + 1'b1;
        end
    end

    // The first tile of a group starts from zero, never from the previous result.
    assign acc_b    = (tile_idx == '0) ? '0 : acc_reg;
    assign out_data = acc_reg;

endmodule

// File: tb/tb_psum_buffer.sv
// tb/tb_psum_buffer.sv - randomized self-checking bench for psum_buffer with a behavioural accumulator
module tb_psum_buffer;

    localparam int AW   = 18;
    localparam int SW   = 21;
    localparam int COLS = 2;
    localparam int TC   = 4;
    localparam int TW   = $clog2(TC + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [AW*COLS-1:0]   psum_in;
    logic [SW*COLS-1:0]   acc_b;
    logic [SW*COLS-1:0]   acc_sum;
    logic                 out_valid;
    logic                 out_ready;
    logic [SW*COLS-1:0]   out_data;
    logic [TW-1:0]        tile_idx;
    logic [SW-1:0]        bias0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [SW-1:0] m_acc0, m_acc1;
    int            m_cnt;
    bit            m_hold;

    psum_buffer #(
        .acc_width(AW), .actual_width(SW), .systolic_column(COLS),
        .pe_blk_count(1), .tile_count(TC)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .psum_in(psum_in), .acc_b(acc_b), .acc_sum(acc_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .tile_idx(tile_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [SW-1:0] sx(input logic [AW-1:0] v);
        return {{(SW-AW){v[AW-1]}}, v};
    endfunction

    // Accumulator in the loop: A = psum_in sign-extended, B = acc_b; bias0 lets a test push column 0 past range.
    always_comb begin
        acc_sum[SW-1:0]    = sx(psum_in[AW-1:0]) + acc_b[SW-1:0] + bias0;
        acc_sum[2*SW-1:SW] = sx(psum_in[2*AW-1:AW]) + acc_b[2*SW-1:SW];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_acc0 = '0;
        m_acc1 = '0;
        m_cnt  = 0;
        m_hold = 0;
    endtask

    task automatic cycle(input bit v, input logic [AW-1:0] c0, input logic [AW-1:0] c1, input bit ordy);
        bit            rdy;
        logic [SW-1:0] t0, t1;
        in_valid  = v;
        psum_in   = {c1, c0};
        out_ready = ordy;
        #1;
        rdy = m_hold ? ordy : 1'b1;
        check("in_ready", 64'(in_ready), 64'(rdy));
        check("out_valid", 64'(out_valid), 64'(m_hold));
        check("tile_idx", 64'(tile_idx), 64'(m_cnt));
        check("out_data0", 64'(out_data[SW-1:0]), 64'(m_acc0));
        check("out_data1", 64'(out_data[2*SW-1:SW]), 64'(m_acc1));
        check("acc_b0", 64'(acc_b[SW-1:0]), (m_cnt == 0) ? 64'd0 : 64'(m_acc0));
        check("acc_b1", 64'(acc_b[2*SW-1:SW]), (m_cnt == 0) ? 64'd0 : 64'(m_acc1));
        t0 = sx(c0) + bias0;
        t1 = sx(c1);
        @(posedge clk);
        if (m_hold && ordy) m_hold = 0;
        if (v && rdy) begin
            if (m_cnt == 0) begin
                m_acc0 = t0;
                m_acc1 = t1;
            end else begin
                m_acc0 = m_acc0 + t0;
                m_acc1 = m_acc1 + t1;
            end
            m_cnt++;
            if (m_cnt == TC) begin
                m_cnt  = 0;
                m_hold = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_tile_idx", 64'(tile_idx), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_acc_b", 64'(acc_b), 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] r0, r1;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; psum_in = '0; bias0 = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Accumulate (1,-1)..(4,-4), result present for exactly one cycle
        for (int i = 1; i <= 4; i++) cycle(1, AW'(i), AW'(-i), 1);
        check("acc_valid", 64'(out_valid), 64'd1);
        check("acc_res0", 64'(out_data[SW-1:0]), 64'd10);
        check("acc_res1", 64'(out_data[2*SW-1:SW]), 64'h1FFFF6);
        cycle(0, '0, '0, 1);
        check("acc_one_cycle", 64'(out_valid), 64'd0);

        // Backpressure then back-to-back start of next group
        for (int i = 1; i <= 4; i++) cycle(1, AW'(i), AW'(-i), 0);
        for (int i = 0; i < 5; i++) cycle(1, AW'(7), AW'(7), 0);
        cycle(1, AW'(7), AW'(7), 1);
        check("b2b_tile_idx", 64'(tile_idx), 64'd1);
        check("b2b_acc_b0", 64'(acc_b[SW-1:0]), 64'd7);
        check("b2b_acc_b1", 64'(acc_b[2*SW-1:SW]), 64'd7);
        for (int i = 0; i < 3; i++) cycle(1, AW'(1), AW'(1), 1);
        check("b2b_res0", 64'(out_data[SW-1:0]), 64'd10);
        cycle(0, '0, '0, 1);

        // Maximum positive tiles, then a forced overflow past 2^20-1
        for (int i = 0; i < 4; i++) cycle(1, AW'(131071), AW'(131071), 1);
        check("max_res0", 64'(out_data[SW-1:0]), 64'd524284);
        check("max_res1", 64'(out_data[2*SW-1:SW]), 64'd524284);
        cycle(0, '0, '0, 1);
        bias0 = 21'h0FFFFF;
        cycle(1, AW'(131071), AW'(131071), 1);
        bias0 = '0;
        for (int i = 0; i < 3; i++) cycle(1, AW'(131071), AW'(131071), 1);
        check("wrap_res0", 64'(out_data[SW-1:0]), 64'h17FFFB);
        check("wrap_sign", 64'(out_data[SW-1]), 64'd1);
        cycle(0, '0, '0, 1);

        // Reset after two tiles discards them
        cycle(1, AW'(100), AW'(200), 1);
        cycle(1, AW'(100), AW'(200), 1);
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, AW'(5), AW'(-6), 1);
        check("rst_mid_res0", 64'(out_data[SW-1:0]), 64'd20);
        check("rst_mid_res1", 64'(out_data[2*SW-1:SW]), 64'h1FFFE8);
        cycle(0, '0, '0, 1);

        // Random gaps and backpressure
        for (int i = 0; i < 400; i++) begin
            r0 = AW'($urandom);
            r1 = AW'($urandom);
            cycle(bit'($urandom_range(0, 1)), r0, r1, $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
